// File: rtl/amf_window_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// amf_window_ctrl_pkg
// Shared constants for the adaptive median filter window controller.
//   - FSM state encodings used by amf_window_ctrl
//   - Window level indices (level 0 is the 3x3 window, each step adds a ring)
// ----------------------------------------------------------------------------
package amf_window_ctrl_pkg;

    // Controller states, kept as plain 2-bit constants so the encoding is
    // fixed and visible to anything that inspects the state register.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_EVAL = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    // Window level indices handed to the median engine.
    localparam int unsigned LVL_3X3 = 0;
    localparam int unsigned LVL_5X5 = 1;
    localparam int unsigned LVL_7X7 = 2;

endpackage

// File: rtl/amf_window_ctrl_noise_cmp.sv
// ----------------------------------------------------------------------------
// amf_noise_cmp
// Classifies a pixel as salt/pepper noise against two fixed thresholds.
// A value at or below T1 is pepper, at or above T2 is salt; both are noise.
// Ports:
//   v        in   DATA_WIDTH  pixel value under test
//   is_noise out  1           high when v is considered impulse noise
// ----------------------------------------------------------------------------
module amf_noise_cmp
    import amf_window_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned T1         = 0,
    parameter int unsigned T2         = 255
) (
    input  logic [DATA_WIDTH-1:0] v,
    output logic                  is_noise
);

    localparam logic [DATA_WIDTH-1:0] PepperMax = DATA_WIDTH'(T1);
    localparam logic [DATA_WIDTH-1:0] SaltMin   = DATA_WIDTH'(T2);

    // Unsigned compare: both thresholds are inclusive.
    assign is_noise = (v <= PepperMax) || (v >= SaltMin);

endmodule

// File: rtl/amf_window_ctrl.sv
// ----------------------------------------------------------------------------
// amf_window_ctrl
// Per-pixel sequencer of the adaptive median filter. A window-centre pixel is
// tested for impulse noise; clean pixels pass straight to the output, noisy
// ones trigger median requests at growing window levels until the returned
// median is clean or the largest window has been used.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     centre pixel handshake, in_pixel carries the pixel
//   med_req/med_level     median request and requested window level
//   med_ack/med_value     median engine response
//   out_valid/out_ready   filtered pixel handshake
//   out_pixel             filtered pixel
//   out_level             last window level used (0 when bypassed)
//   out_replaced          1 when out_pixel is a median
//   noise_cnt             saturating count of noisy centre pixels
// ----------------------------------------------------------------------------
module amf_window_ctrl
    import amf_window_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned T1          = 0,
    parameter int unsigned T2          = 255,
    parameter int unsigned MAX_LEVEL   = 2,
    parameter int unsigned LEVEL_WIDTH = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_pixel,
    output logic                   med_req,
    output logic [LEVEL_WIDTH-1:0] med_level,
    input  logic                   med_ack,
    input  logic [DATA_WIDTH-1:0]  med_value,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_pixel,
    output logic [LEVEL_WIDTH-1:0] out_level,
    output logic                   out_replaced,
    output logic [CNT_WIDTH-1:0]   noise_cnt
);

    localparam logic [LEVEL_WIDTH-1:0] LevelMax   = LEVEL_WIDTH'(MAX_LEVEL);
    localparam logic [LEVEL_WIDTH-1:0] LevelFirst = LEVEL_WIDTH'(LVL_3X3);

    logic [1:0]             state_q,        state_d;
    logic [LEVEL_WIDTH-1:0] level_q,        level_d;
    logic [DATA_WIDTH-1:0]  med_q,          med_d;
    logic [DATA_WIDTH-1:0]  out_pixel_q,    out_pixel_d;
    logic [LEVEL_WIDTH-1:0] out_level_q,    out_level_d;
    logic                   out_replaced_q, out_replaced_d;
    logic [CNT_WIDTH-1:0]   noise_cnt_q,    noise_cnt_d;

    logic in_noise;
    logic med_noise;

    // One comparator judges the incoming centre pixel, the other judges the
    // median latched from the engine while the FSM sits in EVAL.
    amf_noise_cmp #(
        .DATA_WIDTH(DATA_WIDTH),
        .T1        (T1),
        .T2        (T2)
    ) u_in_cmp (
        .v        (in_pixel),
        .is_noise (in_noise)
    );

    amf_noise_cmp #(
        .DATA_WIDTH(DATA_WIDTH),
        .T1        (T1),
        .T2        (T2)
    ) u_med_cmp (
        .v        (med_q),
        .is_noise (med_noise)
    );

    // Next-state logic. Output fields only change when a result is produced,
    // so they stay stable for the whole time the FSM waits in OUT.
    always_comb begin
        state_d        = state_q;
        level_d        = level_q;
        med_d          = med_q;
        out_pixel_d    = out_pixel_q;
        out_level_d    = out_level_q;
        out_replaced_d = out_replaced_q;
        noise_cnt_d    = noise_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_noise) begin
                        noise_cnt_d = (noise_cnt_q == '1) ? noise_cnt_q
                                                          : noise_cnt_q + CNT_WIDTH'(1);
                        level_d     = LevelFirst;
                        state_d     = ST_REQ;
                    end else begin
                        out_pixel_d    = in_pixel;
                        out_replaced_d = 1'b0;
                        out_level_d    = '0;
                        state_d        = ST_OUT;
                    end
                end
            end
            ST_REQ: begin
                // Acks are only honoured here; strays in other states are dropped.
                if (med_ack) begin
                    med_d   = med_value;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                // A noisy median at the largest window is accepted anyway.
                if (!med_noise || (level_q == LevelMax)) begin
                    out_pixel_d    = med_q;
                    out_replaced_d = 1'b1;
                    out_level_d    = level_q;
                    state_d        = ST_OUT;
                end else begin
                    level_d = level_q + LEVEL_WIDTH'(1);
                    state_d = ST_REQ;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; a reset mid-request simply
    // returns to IDLE, so a late ack lands in IDLE and is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            level_q        <= '0;
            med_q          <= '0;
            out_pixel_q    <= '0;
            out_level_q    <= '0;
            out_replaced_q <= 1'b0;
            noise_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            med_q          <= med_d;
            out_pixel_q    <= out_pixel_d;
            out_level_q    <= out_level_d;
            out_replaced_q <= out_replaced_d;
            noise_cnt_q    <= noise_cnt_d;
        end
    end

    // Handshake outputs decode directly from the state, which keeps
    // in_ready and out_valid mutually exclusive by construction.
    assign in_ready     = (state_q == ST_IDLE);
    assign med_req      = (state_q == ST_REQ);
    assign med_level    = level_q;
    assign out_valid    = (state_q == ST_OUT);
    assign out_pixel    = out_pixel_q;
    assign out_level    = out_level_q;
    assign out_replaced = out_replaced_q;
    assign noise_cnt    = noise_cnt_q;

endmodule

// File: tb/tb_amf_window_ctrl.sv
// ----------------------------------------------------------------------------
// tb_amf_window_ctrl
// Directed bench for amf_window_ctrl. A second instance with a 2-bit noise
// counter shares all inputs so counter saturation can be observed.
// ----------------------------------------------------------------------------
module tb_amf_window_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_pixel = 8'd0;
    logic       med_ack = 1'b0;
    logic [7:0] med_value = 8'd0;
    logic       out_ready = 1'b0;

    logic        in_ready, med_req, out_valid, out_replaced;
    logic [1:0]  med_level, out_level;
    logic [7:0]  out_pixel;
    logic [15:0] noise_cnt;

    logic       in_ready2, med_req2, out_valid2, out_replaced2;
    logic [1:0] med_level2, out_level2, noise_cnt2;
    logic [7:0] out_pixel2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    amf_window_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pixel     (in_pixel),
        .med_req      (med_req),
        .med_level    (med_level),
        .med_ack      (med_ack),
        .med_value    (med_value),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pixel    (out_pixel),
        .out_level    (out_level),
        .out_replaced (out_replaced),
        .noise_cnt    (noise_cnt)
    );

    amf_window_ctrl #(.CNT_WIDTH(2)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready2),
        .in_pixel     (in_pixel),
        .med_req      (med_req2),
        .med_level    (med_level2),
        .med_ack      (med_ack),
        .med_value    (med_value),
        .out_valid    (out_valid2),
        .out_ready    (out_ready),
        .out_pixel    (out_pixel2),
        .out_level    (out_level2),
        .out_replaced (out_replaced2),
        .noise_cnt    (noise_cnt2)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pixel for a single accepting edge.
    task automatic applyStimulus(input logic [7:0] pix);
        in_valid = 1'b1;
        in_pixel = pix;
        tick();
        in_valid = 1'b0;
    endtask

    // Answer one median request at the expected level after 'delay' cycles,
    // checking the request is held stable while waiting and drops in EVAL.
    task automatic serveRequest(input logic [1:0] expLevel, input logic [7:0] value,
                                input int delay);
        int waited = 0;
        while (!med_req && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput("med_req_seen", 32'(med_req), 32'd1);
        checkOutput("med_level", 32'(med_level), 32'(expLevel));
        for (int i = 0; i < delay; i++) begin
            tick();
            checkOutput("med_req_held", 32'(med_req), 32'd1);
            checkOutput("med_level_held", 32'(med_level), 32'(expLevel));
        end
        med_ack   = 1'b1;
        med_value = value;
        tick();
        med_ack   = 1'b0;
        checkOutput("med_req_gap", 32'(med_req), 32'd0);
    endtask

    // Bounded wait for a result, then accept it.
    task automatic drainOutput();
        int waited = 0;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput("out_valid_seen", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("back_to_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_med_req", 32'(med_req), 32'd0);
        checkOutput("rst_med_level", 32'(med_level), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_pixel", 32'(out_pixel), 32'd0);
        checkOutput("rst_out_level", 32'(out_level), 32'd0);
        checkOutput("rst_out_replaced", 32'(out_replaced), 32'd0);
        checkOutput("rst_noise_cnt", 32'(noise_cnt), 32'd0);
        rst = 1'b0;

        // Clean pixel bypass with latency 1
        applyStimulus(8'd100);
        checkOutput("byp_out_valid", 32'(out_valid), 32'd1);
        checkOutput("byp_out_pixel", 32'(out_pixel), 32'd100);
        checkOutput("byp_replaced", 32'(out_replaced), 32'd0);
        checkOutput("byp_level", 32'(out_level), 32'd0);
        checkOutput("byp_noise_cnt", 32'(noise_cnt), 32'd0);
        checkOutput("byp_med_req", 32'(med_req), 32'd0);
        checkOutput("byp_in_ready", 32'(in_ready), 32'd0);
        drainOutput();

        // Single-level replacement, best-case latency 3
        applyStimulus(8'd255);
        checkOutput("s1_req_next", 32'(med_req), 32'd1);
        serveRequest(2'd0, 8'd120, 0);
        tick();
        checkOutput("s1_out_valid_lat3", 32'(out_valid), 32'd1);
        checkOutput("s1_out_pixel", 32'(out_pixel), 32'd120);
        checkOutput("s1_replaced", 32'(out_replaced), 32'd1);
        checkOutput("s1_level", 32'(out_level), 32'd0);
        checkOutput("s1_noise_cnt", 32'(noise_cnt), 32'd1);
        drainOutput();

        // Level growth: medians 0 and 255 are noise, 90 is clean
        applyStimulus(8'd0);
        serveRequest(2'd0, 8'd0, 0);
        tick();
        serveRequest(2'd1, 8'd255, 0);
        tick();
        serveRequest(2'd2, 8'd90, 0);
        tick();
        checkOutput("lg_out_valid", 32'(out_valid), 32'd1);
        checkOutput("lg_out_pixel", 32'(out_pixel), 32'd90);
        checkOutput("lg_level", 32'(out_level), 32'd2);
        checkOutput("lg_noise_cnt", 32'(noise_cnt), 32'd2);
        drainOutput();

        // Max level exhausted: noisy median accepted at level 2, then backpressure
        applyStimulus(8'd255);
        serveRequest(2'd0, 8'd255, 0);
        tick();
        serveRequest(2'd1, 8'd0, 0);
        tick();
        serveRequest(2'd2, 8'd255, 0);
        tick();
        checkOutput("mx_no_4th_req", 32'(med_req), 32'd0);
        checkOutput("mx_out_valid", 32'(out_valid), 32'd1);
        checkOutput("mx_out_pixel", 32'(out_pixel), 32'd255);
        checkOutput("mx_level", 32'(out_level), 32'd2);
        checkOutput("mx_replaced", 32'(out_replaced), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_out_pixel", 32'(out_pixel), 32'd255);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        end
        drainOutput();

        // Stray ack in IDLE is ignored
        med_ack   = 1'b1;
        med_value = 8'd7;
        tick();
        med_ack   = 1'b0;
        checkOutput("stray_med_req", 32'(med_req), 32'd0);
        checkOutput("stray_out_valid", 32'(out_valid), 32'd0);
        checkOutput("stray_in_ready", 32'(in_ready), 32'd1);
        checkOutput("stray_noise_cnt", 32'(noise_cnt), 32'd3);

        // Delayed ack: request held for 4 cycles
        applyStimulus(8'd0);
        serveRequest(2'd0, 8'd50, 4);
        tick();
        checkOutput("dl_out_pixel", 32'(out_pixel), 32'd50);
        checkOutput("dl_level", 32'(out_level), 32'd0);
        drainOutput();

        // Reset during REQ aborts; a late ack is ignored
        applyStimulus(8'd255);
        checkOutput("mr_req", 32'(med_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mr_med_req", 32'(med_req), 32'd0);
        checkOutput("mr_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mr_noise_cnt", 32'(noise_cnt), 32'd0);
        med_ack   = 1'b1;
        med_value = 8'd33;
        tick();
        med_ack   = 1'b0;
        checkOutput("mr_late_ack_valid", 32'(out_valid), 32'd0);
        checkOutput("mr_late_ack_ready", 32'(in_ready), 32'd1);

        // Five noisy pixels: 16-bit counter reads 5, 2-bit counter saturates at 3
        for (int n = 0; n < 5; n++) begin
            applyStimulus(8'd255);
            serveRequest(2'd0, 8'd100, 0);
            tick();
            drainOutput();
        end
        checkOutput("sat_cnt16", 32'(noise_cnt), 32'd5);
        checkOutput("sat_cnt2", 32'(noise_cnt2), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/amf_window_ctrl.md
Name: amf_window_ctrl

Overview:
- Per-pixel sequencer for the adaptive median filter.
- Accepts a window-centre pixel and classifies it as salt/pepper noise against thresholds T1/T2.
- Clean pixels bypass; noisy pixels get a median request to the median engine at window level 0 (3x3).
- The level grows (5x5, 7x7, ...) while the returned median is itself noise, up to MAX_LEVEL; the result then goes out on a valid/ready output with a saturating noise counter.

Parameters:
- DATA_WIDTH, 8, pixel width.
- T1, 0, pepper threshold; value <= T1 is noise.
- T2, 255, salt threshold; value >= T2 is noise.
- MAX_LEVEL, 2, highest window level index (0=3x3, 1=5x5, 2=7x7).
- LEVEL_WIDTH, 2, width of level fields; must hold MAX_LEVEL.
- CNT_WIDTH, 16, width of noise counter.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, centre pixel valid.
- in_ready, output, 1, controller can accept pixel.
- in_pixel, input, DATA_WIDTH, window-centre pixel.
- med_req, output, 1, median request to median engine.
- med_level, output, LEVEL_WIDTH, requested window level; stable while med_req=1.
- med_ack, input, 1, median engine returns result.
- med_value, input, DATA_WIDTH, median of requested window; valid when med_ack=1.
- out_valid, output, 1, filtered pixel valid.
- out_ready, input, 1, downstream accepts.
- out_pixel, output, DATA_WIDTH, filtered pixel.
- out_level, output, LEVEL_WIDTH, last level used (0 on bypass).
- out_replaced, output, 1, 1 if out_pixel is a median, 0 if bypassed.
- noise_cnt, output, CNT_WIDTH, count of noisy centre pixels since reset; saturates at all-ones.

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, in_ready=1, med_req=0, med_level=0, out_valid=0, out_pixel=0, out_level=0, out_replaced=0, noise_cnt=0. Reset mid-operation aborts any pending request or output the next edge; a med_ack arriving after reset is ignored.
- Noise test, combinational, unsigned: isNoise(v) = (v <= T1) || (v >= T2).
- FSM states: IDLE, REQ, EVAL, OUT.
- IDLE: in_ready=1. On in_valid, latch in_pixel.
  - Not noise: out_pixel=in_pixel, out_replaced=0, out_level=0, go OUT. out_valid rises the cycle after acceptance (latency 1).
  - Noise: noise_cnt += 1 (saturating), level=0, go REQ.
- REQ: med_req=1, med_level=level, held until med_ack.
  - med_ack while med_req=1: latch med_value, go EVAL.
  - med_ack in any other state is ignored.
- EVAL (one cycle, med_req=0):
  - Median not noise, or level==MAX_LEVEL: out_pixel=median, out_replaced=1, out_level=level, go OUT.
  - Otherwise: level += 1, go REQ. med_req deasserts for exactly one cycle between consecutive requests.
- OUT: out_valid=1; out_pixel, out_level, out_replaced stable until out_ready. On out_valid && out_ready, go IDLE.
- in_ready=1 only in IDLE; no pixel is accepted during REQ/EVAL/OUT. out_valid and in_ready are never both 1.
- Best-case noisy latency: accept, REQ (ack same cycle), EVAL, OUT gives out_valid 3 cycles after acceptance.
- Level never exceeds MAX_LEVEL. With MAX_LEVEL=0 only a single request is issued.

Decomposition:
- Shared package/header holds state encodings (IDLE=0, REQ=1, EVAL=2, OUT=3) and level constants (LVL_3X3=0, LVL_5X5=1, LVL_7X7=2).
- Threshold compare is a natural small sub-module, amf_noise_cmp (DATA_WIDTH, T1, T2; in v, out is_noise). It is instantiated twice: on in_pixel and on the latched median.

Test Plan:
- Reset/bypass: rst high 2 cycles, all outputs 0, in_ready=1. Then in_pixel=100 -> out_valid next cycle, out_pixel=100, out_replaced=0, out_level=0, noise_cnt=0, med_req never asserted.
- Single-level replace: in_pixel=255; ack level 0 with med_value=120 -> med_req/med_level=0 one cycle after acceptance; out_pixel=120, out_replaced=1, out_level=0, noise_cnt=1.
- Level growth: in_pixel=0; medians 0, 255, 90 -> med_level sequence 0,1,2 with a med_req=0 gap between requests; out_pixel=90, out_level=2.
- Max level exhausted: in_pixel=255; medians 255, 0, 255 -> exactly 3 requests; out_pixel=255, out_level=2, out_replaced=1.
- Backpressure/handshakes: out_ready=0 for 5 cycles -> out_pixel stable, in_ready=0 throughout. Stray med_ack in IDLE -> ignored. med_ack delayed 4 cycles -> med_req and med_level held stable.
- Reset mid-request and saturation: rst asserted in REQ -> IDLE next edge, med_req=0. With CNT_WIDTH=2, 5 noisy pixels -> noise_cnt=3.
